ecc_secded_pipe: RTL

- Parametrised, pipelined SECDED (single-error-correct, double-error-detect) decoder/encoder for FIFO and RAM read paths.
- Generalises the fixed 57-bit combinational ECC to any data width.
- Adds a valid/ready handshake, a 2-stage pipeline with backpressure, saturating error counters and a sticky first-uncorrectable-error log.
- Sits between a storage macro read port and the FIFO read-data consumer.

---
 rtl/ecc_secded_pipe_if.sv | 32 +++
 rtl/ecc_secded_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ecc_secded_pipe_if.sv
// Read-path handshake bundle for the SECDED pipeline: storage-side input word
// and consumer-side corrected output word.
interface ecc_secded_pipe_if #(
  parameter int DATA_WIDTH   = 57,
  parameter int PARITY_WIDTH = 7
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [PARITY_WIDTH-1:0] in_parity;
  logic                    in_bypass;

  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [PARITY_WIDTH-1:0] out_parity;
  logic [PARITY_WIDTH-1:0] out_syndrome;
  logic                    out_sbit_err;
  logic                    out_dbit_err;

  modport master (
    output in_valid, in_data, in_parity, in_bypass, out_ready,
    input  in_ready, out_valid, out_data, out_parity, out_syndrome,
           out_sbit_err, out_dbit_err
  );

  modport slave (
    input  in_valid, in_data, in_parity, in_bypass, out_ready,
    output in_ready, out_valid, out_data, out_parity, out_syndrome,
           out_sbit_err, out_dbit_err
  );
endinterface

// File: rtl/ecc_secded_pipe.sv
// Parametrised two-stage SECDED decoder for storage read paths, with
// valid/ready backpressure, saturating error counters and a first-DED log.
module ecc_secded_pipe #(
  parameter int DATA_WIDTH   = 57,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  ecc_secded_pipe_if.slave        bus,
  input  logic                    cnt_clr,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic                    dlog_valid,
  output logic [PARITY_WIDTH-1:0] dlog_syndrome
);
  localparam int R = PARITY_WIDTH - 1;

  function automatic int parity_bits(input int dw);
    int r;
    r = 0;
    for (int t = 1; t < 16; t++)
      if (r == 0 && (1 << t) >= dw + t + 1) r = t;
    return r + 1;
  endfunction

  // Codeword position of data bit idx: skip every power of two at or below it.
  function automatic int pos_of(input int idx);
    int p;
    p = idx + 1;
    for (int j = 0; j < 10; j++)
      if ((1 << j) <= p) p++;
    return p;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] cover_mask(input int k);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      m[i] = ((pos_of(i) >> k) & 1) != 0;
    return m;
  endfunction

  if (DATA_WIDTH < 4 || DATA_WIDTH > 247) begin : g_bad_dw
    $error("ecc_secded_pipe: DATA_WIDTH %0d outside 4..247", DATA_WIDTH);
  end
  if (PARITY_WIDTH != parity_bits(DATA_WIDTH)) begin : g_bad_pw
    $error("ecc_secded_pipe: PARITY_WIDTH %0d, need %0d", PARITY_WIDTH,
           parity_bits(DATA_WIDTH));
  end

  logic [PARITY_WIDTH-1:0] enc;
  logic [PARITY_WIDTH-1:0] syn;

  for (genvar k = 0; k < R; k++) begin : g_enc
    localparam logic [DATA_WIDTH-1:0] MASK = cover_mask(k);
    assign enc[k] = ^(bus.in_data & MASK);
  end
  assign enc[R] = ^bus.in_data ^ ^enc[R-1:0];

  assign syn[R-1:0] = bus.in_parity[R-1:0] ^ enc[R-1:0];
  // Overall bit spans the received check bits too, so a lone check-bit flip reads odd.
  assign syn[R]     = ^bus.in_parity ^ ^bus.in_data;

  logic                    s1_valid;
  logic                    s1_byp;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [PARITY_WIDTH-1:0] s1_syn;
  logic [PARITY_WIDTH-1:0] s1_par;

  logic                    s2_valid;
  logic                    s2_sbit;
  logic                    s2_dbit;
  logic [DATA_WIDTH-1:0]   s2_data;
  logic [PARITY_WIDTH-1:0] s2_syn;
  logic [PARITY_WIDTH-1:0] s2_par;

  logic s2_load;
  logic s1_load;
  logic out_xfer;

  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_load      = !s1_valid || s2_load;
  assign out_xfer     = s2_valid && bus.out_ready;
  assign bus.in_ready = !rst && s1_load;

  logic [R-1:0]          s1_h;
  logic [DATA_WIDTH-1:0] hit;
  logic                  h_pow2;

  assign s1_h   = s1_syn[R-1:0];
  assign h_pow2 = (s1_h & (s1_h - R'(1))) == '0;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_hit
    localparam logic [R-1:0] POS = R'(pos_of(i));
    assign hit[i] = (s1_h == POS);
  end

  logic [DATA_WIDTH-1:0] corr;
  logic                  c_sbit;
  logic                  c_dbit;

  always_comb begin
    corr   = s1_data;
    c_sbit = 1'b0;
    c_dbit = 1'b0;
    if (!s1_byp && s1_syn != '0) begin
      if (!s1_syn[R]) begin
        c_dbit = 1'b1;
      end else if (h_pow2) begin
        c_sbit = 1'b1;
      end else if (|hit) begin
        c_sbit = 1'b1;
        corr   = s1_data ^ hit;
      end else begin
        c_dbit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_byp   <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_par   <= '0;
      s2_valid <= 1'b0;
      s2_sbit  <= 1'b0;
      s2_dbit  <= 1'b0;
      s2_data  <= '0;
      s2_syn   <= '0;
      s2_par   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_byp  <= bus.in_bypass;
          s1_data <= bus.in_data;
          s1_syn  <= syn;
          s1_par  <= enc;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sbit <= c_sbit;
          s2_dbit <= c_dbit;
          s2_data <= corr;
          s2_syn  <= s1_syn;
          s2_par  <= s1_par;
        end
      end
    end
  end

  assign bus.out_valid    = s2_valid;
  assign bus.out_data     = s2_data;
  assign bus.out_parity   = s2_par;
  assign bus.out_syndrome = s2_syn;
  assign bus.out_sbit_err = s2_sbit;
  assign bus.out_dbit_err = s2_dbit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbit_cnt      <= '0;
      dbit_cnt      <= '0;
      dlog_valid    <= 1'b0;
      dlog_syndrome <= '0;
    end else if (cnt_clr) begin
      sbit_cnt      <= '0;
      dbit_cnt      <= '0;
      dlog_valid    <= 1'b0;
      dlog_syndrome <= '0;
    end else begin
      if (out_xfer && s2_sbit && sbit_cnt != '1)
        sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
      if (out_xfer && s2_dbit && dbit_cnt != '1)
        dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
      if (out_xfer && s2_dbit && !dlog_valid) begin
        dlog_valid    <= 1'b1;
        dlog_syndrome <= s2_syn;
      end
    end
  end
endmodule
